// File: rtl/mem_port_arbiter_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_ctrl
// Purpose  : Shares one single-port memory between instruction fetch (IF)
//            and data access (MEM). Each access is sequenced through a
//            request/ready handshake with wait states. On completion the
//            granted done output pulses for one cycle (if_done_o doubles as
//            the IR load enable). lmd_o pulses with mem_done_o on loads.
//            Read data bypasses this block.
// Ports    : clk, rst_n (async, active-low)
//            if_req_i / if_addr_i / if_done_o          fetch requester
//            mem_req_i / mem_we_i / mem_addr_i /
//            mem_wdata_i / mem_done_o / lmd_o          data requester
//            m_en_o / m_we_o / m_addr_o / m_wdata_o /
//            m_ready_i                                 memory side
//            m_timeout_o                               sticky timeout flag
// Config   : MEM_TIMEOUT_EN - when defined, an access stalled for TO_CYCLES
//            ACC cycles is terminated and m_timeout_o is set (sticky).
//            When undefined, ACC waits indefinitely and m_timeout_o is 0.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter_ctrl #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TO_CYCLES = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          if_req_i,
  input  logic [AW-1:0] if_addr_i,
  output logic          if_done_o,
  input  logic          mem_req_i,
  input  logic          mem_we_i,
  input  logic [AW-1:0] mem_addr_i,
  input  logic [DW-1:0] mem_wdata_i,
  output logic          mem_done_o,
  output logic          lmd_o,
  output logic          m_en_o,
  output logic          m_we_o,
  output logic [AW-1:0] m_addr_o,
  output logic [DW-1:0] m_wdata_o,
  input  logic          m_ready_i,
  output logic          m_timeout_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ACC  = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  if (TO_CYCLES < 2) begin : g_to_cycles_check
    $error("TO_CYCLES must be >= 2");
  end

  logic [1:0]    state_q, state_d;
  logic          last_mem_q, last_mem_d;   // 1: last grant went to MEM
  logic          if_done_q, if_done_d;
  logic          mem_done_q, mem_done_d;
  logic          lmd_q, lmd_d;
  logic          m_en_q, m_en_d;
  logic          m_we_q, m_we_d;
  logic [AW-1:0] m_addr_q, m_addr_d;
  logic [DW-1:0] m_wdata_q, m_wdata_d;
  logic          pick_mem;
  logic          to_hit;

  // On a tie the requester that did not win last time is granted.
  assign pick_mem = mem_req_i && (!if_req_i || !last_mem_q);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TO_CYCLES + 1);

  logic [CW-1:0] wait_cnt_q;
  logic          m_timeout_q, m_timeout_d;

  // Terminal count is TO_CYCLES-1 because the hit is taken on the edge that
  // would otherwise make the count reach TO_CYCLES.
  assign to_hit = (state_q == S_ACC) && !m_ready_i &&
                  (wait_cnt_q == CW'(TO_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wait_cnt_q <= '0;
    end else if (state_q != S_ACC) begin
      wait_cnt_q <= '0;
    end else if (!m_ready_i) begin
      wait_cnt_q <= wait_cnt_q + 1'b1;
    end
  end

  assign m_timeout_d = m_timeout_q | to_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_timeout_q <= 1'b0;
    end else begin
      m_timeout_q <= m_timeout_d;
    end
  end

  assign m_timeout_o = m_timeout_q;
`else
  assign to_hit      = 1'b0;
  assign m_timeout_o = 1'b0;
`endif

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      last_mem_q <= 1'b0;
      if_done_q  <= 1'b0;
      mem_done_q <= 1'b0;
      lmd_q      <= 1'b0;
      m_en_q     <= 1'b0;
      m_we_q     <= 1'b0;
      m_addr_q   <= '0;
      m_wdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      last_mem_q <= last_mem_d;
      if_done_q  <= if_done_d;
      mem_done_q <= mem_done_d;
      lmd_q      <= lmd_d;
      m_en_q     <= m_en_d;
      m_we_q     <= m_we_d;
      m_addr_q   <= m_addr_d;
      m_wdata_q  <= m_wdata_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (if_req_i || mem_req_i) state_d = S_ACC;
      S_ACC:   if (m_ready_i || to_hit)   state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values of the registered outputs
  always_comb begin
    last_mem_d = last_mem_q;
    if_done_d  = 1'b0;
    mem_done_d = 1'b0;
    lmd_d      = 1'b0;
    m_en_d     = m_en_q;
    m_we_d     = m_we_q;
    m_addr_d   = m_addr_q;
    m_wdata_d  = m_wdata_q;
    case (state_q)
      S_IDLE: begin
        if (if_req_i || mem_req_i) begin
          m_en_d     = 1'b1;
          last_mem_d = pick_mem;
          if (pick_mem) begin
            m_we_d    = mem_we_i;
            m_addr_d  = mem_addr_i;
            m_wdata_d = mem_wdata_i;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr_i;
            m_wdata_d = '0;
          end
        end
      end
      S_ACC: begin
        if (m_ready_i || to_hit) begin
          m_en_d     = 1'b0;
          m_we_d     = 1'b0;
          if_done_d  = !last_mem_q;
          mem_done_d = last_mem_q;
          // m_we_q still holds the granted direction here.
          lmd_d      = last_mem_q && !m_we_q && m_ready_i;
        end
      end
      default: ;
    endcase
  end

  assign if_done_o  = if_done_q;
  assign mem_done_o = mem_done_q;
  assign lmd_o      = lmd_q;
  assign m_en_o     = m_en_q;
  assign m_we_o     = m_we_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;

endmodule
`default_nettype wire
